ckt_sequencer: RTL

Self-checking stimulus controller for the 3-input, 1-output combinational `ckt` block. On `start` it drives `{a,b,c}` through all eight input combinations in ascending order and holds each for a programmable settle time. It samples `y` at the end of each hold and compares the result against a parameterised expected truth table. It sits beside `ckt` in hardware self-test builds and replaces hand-written stimulus sequences with a single go/no-go result.

---
 rtl/ckt_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ckt_sequencer.sv
// Built-in stimulus/response sequencer for a 3-input combinational block:
// walks all eight input vectors, samples y after a settle time and reports go/no-go.
module ckt_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'hE8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [7:0] o_captured,
    output logic [7:0] o_fail_mask,
    output logic [3:0] o_err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_captured;
    logic [7:0] r_fail_mask;
    logic [3:0] r_err_count;

    state_t     w_state_nxt;
    logic [2:0] w_idx_nxt;
    logic [3:0] w_cnt_nxt;
    logic [2:0] w_abc_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_pass_nxt;
    logic [7:0] w_captured_nxt;
    logic [7:0] w_fail_mask_nxt;
    logic [3:0] w_err_count_nxt;
    logic       w_mismatch;
    logic [3:0] w_err_inc;

    assign w_mismatch = i_y ^ EXPECTED[r_idx];
    // At most eight increments, so the 4-bit count cannot wrap.
    assign w_err_inc  = r_err_count + {3'b000, w_mismatch};

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_cnt_nxt       = r_cnt;
        w_abc_nxt       = 3'b000;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_captured_nxt  = r_captured;
        w_fail_mask_nxt = r_fail_mask;
        w_err_count_nxt = r_err_count;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = ST_RUN;
                    w_idx_nxt       = 3'd0;
                    w_cnt_nxt       = 4'd0;
                    w_abc_nxt       = 3'd0;
                    w_busy_nxt      = 1'b1;
                    w_pass_nxt      = 1'b0;
                    w_captured_nxt  = 8'h00;
                    w_fail_mask_nxt = 8'h00;
                    w_err_count_nxt = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                // Abort wins over a sample edge: the current vector is left unrecorded.
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_captured_nxt[r_idx]  = i_y;
                    w_fail_mask_nxt[r_idx] = w_mismatch;
                    w_err_count_nxt        = w_err_inc;
                    w_cnt_nxt              = 4'd0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_inc == 4'd0);
                    end else begin
                        w_idx_nxt  = r_idx + 3'd1;
                        w_abc_nxt  = r_idx + 3'd1;
                        w_busy_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + 4'd1;
                    w_abc_nxt  = r_idx;
                    w_busy_nxt = 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_abc       <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_captured  <= 8'h00;
            r_fail_mask <= 8'h00;
            r_err_count <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_abc       <= w_abc_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_captured  <= w_captured_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign o_a         = r_abc[2];
    assign o_b         = r_abc[1];
    assign o_c         = r_abc[0];
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_captured  = r_captured;
    assign o_fail_mask = r_fail_mask;
    assign o_err_count = r_err_count;

endmodule
